// File: rtl/skut_frame_serializer.sv
// SKUT frame serializer: on each falling edge of i8KHz, reads the 80-channel frame buffer
// and sends a sync word plus channel bytes MSB-first, with one strobe per serial bit.
module skut_frame_serializer #(
  parameter int          CHANNELS  = 80,
  parameter int          HALF      = 40,
  parameter int          BIT_DIV   = 8,
  parameter logic [15:0] SYNC_WORD = 16'hFAF3
) (
  input  logic       iClk,
  input  logic       reset,
  input  logic       i8KHz,
  input  logic [7:0] iRdData,
  output logic [6:0] oRdAddr,
  output logic       oRdEn,
  output logic       oSer,
  output logic       oBitStb,
  output logic       oFrameSync,
  output logic       oBusy,
  output logic       oOverrun
);

  localparam int              DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [6:0]      LAST_CH  = 7'(CHANNELS - 1);
  localparam logic [6:0]      HALF_CH  = 7'(HALF);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  state_t           state_reg;
  logic             sync1_reg, sync2_reg, delay_reg;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       bit_reg;
  logic [6:0]       chan_reg;
  logic [15:0]      shift_reg;
  logic [7:0]       prefetch_reg;
  logic             rd_pend_reg;
  logic [6:0]       rd_addr_reg;
  logic             rd_en_reg;
  logic             bit_stb_reg;
  logic             frame_sync_reg;
  logic             busy_reg;
  logic             overrun_reg;

  logic             fall_det;
  logic             div_wrap;

  // The first half of the channels sits on even addresses, the rest on odd ones.
  function automatic logic [6:0] chan_addr(input logic [6:0] k);
    logic [6:0] off;
    if (k < HALF_CH) begin
      return {k[5:0], 1'b0};
    end
    off = k - HALF_CH;
    return {off[5:0], 1'b1};
  endfunction

  assign fall_det = ~sync2_reg & delay_reg;
  assign div_wrap = (div_reg == DIV_LAST);

  always_ff @(posedge iClk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      delay_reg      <= 1'b0;
      div_reg        <= '0;
      bit_reg        <= '0;
      chan_reg       <= '0;
      shift_reg      <= '0;
      prefetch_reg   <= '0;
      rd_pend_reg    <= 1'b0;
      rd_addr_reg    <= '0;
      rd_en_reg      <= 1'b0;
      bit_stb_reg    <= 1'b0;
      frame_sync_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      sync1_reg   <= i8KHz;
      sync2_reg   <= sync1_reg;
      delay_reg   <= sync2_reg;
      rd_pend_reg <= rd_en_reg;
      if (rd_pend_reg) begin
        prefetch_reg <= iRdData;
      end
      rd_en_reg   <= 1'b0;
      bit_stb_reg <= 1'b0;
      overrun_reg <= fall_det && (state_reg != IDLE);

      case (state_reg)
        IDLE: begin
          if (fall_det) begin
            state_reg      <= SYNC;
            div_reg        <= '0;
            bit_reg        <= '0;
            chan_reg       <= '0;
            shift_reg      <= SYNC_WORD;
            bit_stb_reg    <= 1'b1;
            frame_sync_reg <= 1'b1;
            busy_reg       <= 1'b1;
            rd_en_reg      <= 1'b1;
            rd_addr_reg    <= chan_addr(7'd0);
          end
        end

        SYNC: begin
          if (div_wrap) begin
            div_reg     <= '0;
            bit_stb_reg <= 1'b1;
            if (bit_reg == 4'd15) begin
              state_reg      <= DATA;
              bit_reg        <= '0;
              shift_reg      <= {prefetch_reg, 8'h00};
              frame_sync_reg <= 1'b0;
            end else begin
              bit_reg   <= bit_reg + 4'd1;
              shift_reg <= {shift_reg[14:0], 1'b0};
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end

        DATA: begin
          if (div_wrap) begin
            div_reg <= '0;
            if (bit_reg == 4'd7) begin
              bit_reg <= '0;
              if (chan_reg == LAST_CH) begin
                state_reg <= IDLE;
                chan_reg  <= '0;
                shift_reg <= '0;
                busy_reg  <= 1'b0;
              end else begin
                chan_reg    <= chan_reg + 7'd1;
                shift_reg   <= {prefetch_reg, 8'h00};
                bit_stb_reg <= 1'b1;
              end
            end else begin
              bit_reg     <= bit_reg + 4'd1;
              shift_reg   <= {shift_reg[14:0], 1'b0};
              bit_stb_reg <= 1'b1;
              // Fetch the next byte at the start of bit 7 so it lands before the byte boundary.
              if (bit_reg == 4'd6 && chan_reg != LAST_CH) begin
                rd_en_reg   <= 1'b1;
                rd_addr_reg <= chan_addr(chan_reg + 7'd1);
              end
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oRdAddr    = rd_addr_reg;
  assign oRdEn      = rd_en_reg;
  assign oSer       = shift_reg[15];
  assign oBitStb    = bit_stb_reg;
  assign oFrameSync = frame_sync_reg;
  assign oBusy      = busy_reg;
  assign oOverrun   = overrun_reg;

endmodule

// File: tb/tb_skut_frame_serializer.sv
// Directed bench for skut_frame_serializer: a full 80-channel frame at BIT_DIV=4 and a
// single-channel frame at BIT_DIV=3, with overrun, back-to-back and mid-frame reset cases.
module tb_skut_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       i8k, i8k1;
  logic [7:0] rd_data, rd_data1;
  logic [6:0] rd_addr, rd_addr1;
  logic       rd_en, ser, stb, fsync, busy, ovr;
  logic       rd_en1, ser1, stb1, fsync1, busy1, ovr1;

  skut_frame_serializer #(.CHANNELS(80), .HALF(40), .BIT_DIV(4), .SYNC_WORD(16'hFAF3)) dut (
    .iClk(clk), .reset(rst_n), .i8KHz(i8k), .iRdData(rd_data),
    .oRdAddr(rd_addr), .oRdEn(rd_en), .oSer(ser), .oBitStb(stb),
    .oFrameSync(fsync), .oBusy(busy), .oOverrun(ovr)
  );

  skut_frame_serializer #(.CHANNELS(1), .HALF(40), .BIT_DIV(3), .SYNC_WORD(16'hFAF3)) dut1 (
    .iClk(clk), .reset(rst_n), .i8KHz(i8k1), .iRdData(rd_data1),
    .oRdAddr(rd_addr1), .oRdEn(rd_en1), .oSer(ser1), .oBitStb(stb1),
    .oFrameSync(fsync1), .oBusy(busy1), .oOverrun(ovr1)
  );

  // Frame buffer preloaded with address a -> data a+1, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= {1'b0, rd_addr} + 8'd1;
    if (rd_en1) rd_data1 <= {1'b0, rd_addr1} + 8'd1;
  end

  int   total = 0;
  int   bad = 0;
  int   nbits = 0, nrd = 0, busy_cyc = 0, fs_cyc = 0, novr = 0, glitch = 0, rd_idle = 0;
  int   nbits1 = 0, nrd1 = 0, busy_cyc1 = 0;
  logic bits [0:8191];
  logic bits1 [0:255];
  logic [6:0] rd_log [0:1023];
  logic [6:0] rd_log1 [0:15];
  logic prev_ser = 1'b0;

  always @(negedge clk) begin
    if (stb === 1'b1) begin
      if (nbits < 8192) bits[nbits] <= ser;
      nbits <= nbits + 1;
    end
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (fsync === 1'b1) fs_cyc <= fs_cyc + 1;
    if (ovr === 1'b1) novr <= novr + 1;
    if (rd_en === 1'b1) begin
      if (nrd < 1024) rd_log[nrd] <= rd_addr;
      nrd <= nrd + 1;
      if (busy !== 1'b1) rd_idle <= rd_idle + 1;
    end
    if (busy === 1'b1 && stb !== 1'b1 && ser !== prev_ser) glitch <= glitch + 1;
    prev_ser <= ser;
    if (stb1 === 1'b1) begin
      if (nbits1 < 256) bits1[nbits1] <= ser1;
      nbits1 <= nbits1 + 1;
    end
    if (busy1 === 1'b1) busy_cyc1 <= busy_cyc1 + 1;
    if (rd_en1 === 1'b1) begin
      if (nrd1 < 16) rd_log1[nrd1] <= rd_addr1;
      nrd1 <= nrd1 + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    return (k < 40) ? 8'(2 * k + 1) : 8'(2 * (k - 40) + 2);
  endfunction

  function automatic logic [6:0] exp_addr(input int k);
    return (k < 40) ? 7'(2 * k) : 7'(2 * (k - 40) + 1);
  endfunction

  task automatic verify_frame(input string nm, input int base);
    logic [15:0] w;
    logic [7:0]  b;
    w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], bits[base + i]};
    chk({nm, "_sync"}, 32'(w), 32'hFAF3);
    for (int k = 0; k < 80; k++) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits[base + 16 + 8 * k + i]};
      chk($sformatf("%s_byte%0d", nm, k), 32'(b), 32'(exp_byte(k)));
    end
  endtask

  task automatic start_edge(input string nm);
    i8k = 1'b1;
    repeat (8) step();
    i8k = 1'b0;
    step();
    step();
    chk({nm, "_E_idle"}, 32'(busy), 32'd0);
    step();
    chk({nm, "_E1_out"}, {19'b0, rd_addr, rd_en, ser, stb, fsync, busy, ovr}, 32'h3E);
  endtask

  // Runs from E+1 until busy drops; optionally raises/lowers i8KHz at given offsets.
  task automatic run_to_end(input int hi_at, input int lo_at,
                            output int n, output int fs_n, output int rd2_n);
    n = 0;
    fs_n = -1;
    rd2_n = -1;
    while (busy === 1'b1 && n < 5000) begin
      if (n == hi_at) i8k = 1'b1;
      if (n == lo_at) i8k = 1'b0;
      step();
      n++;
      if (fs_n < 0 && fsync !== 1'b1) fs_n = n;
      if (rd2_n < 0 && rd_en === 1'b1) rd2_n = n;
    end
  endtask

  int n, fs_n, rd2_n;
  int b_bits, b_rd, b_busy, b_fs, b_ovr;

  initial begin
    rst_n = 1'b0;
    i8k   = 1'b0;
    i8k1  = 1'b0;
    repeat (5) step();
    chk("reset_outs", {19'b0, rd_addr, rd_en, ser, stb, fsync, busy, ovr}, 32'd0);
    chk("reset_outs1", {19'b0, rd_addr1, rd_en1, ser1, stb1, fsync1, busy1, ovr1}, 32'd0);

    // Release with i8KHz low: no frame may start.
    rst_n = 1'b1;
    repeat (20) step();
    chk("idle_busy", 32'(busy_cyc), 32'd0);
    chk("idle_reads", 32'(nrd), 32'd0);
    chk("idle_outs", {19'b0, rd_addr, rd_en, ser, stb, fsync, busy, ovr}, 32'd0);
    i8k = 1'b1;
    repeat (10) step();
    chk("rise_no_frame", 32'(busy_cyc), 32'd0);

    // Frame 1: full content, timing and read order.
    start_edge("f1");
    run_to_end(-1, -1, n, fs_n, rd2_n);
    chk("f1_len", 32'(n), 32'd2624);
    chk("f1_end_ser", {30'b0, busy, ser}, 32'd0);
    chk("f1_fs_fall", 32'(fs_n), 32'd64);
    chk("f1_rd2_time", 32'(rd2_n), 32'd92);
    chk("f1_busy_cyc", 32'(busy_cyc), 32'd2624);
    chk("f1_fs_cyc", 32'(fs_cyc), 32'd64);
    chk("f1_bits", 32'(nbits), 32'd656);
    chk("f1_reads", 32'(nrd), 32'd80);
    chk("f1_ovr", 32'(novr), 32'd0);
    verify_frame("f1", 0);
    for (int k = 0; k < 80; k++) chk($sformatf("f1_addr%0d", k), 32'(rd_log[k]), 32'(exp_addr(k)));

    // Frame 2: overrun edge at +1000, then a third edge landing exactly as busy drops.
    b_bits = nbits; b_rd = nrd; b_busy = busy_cyc;
    repeat (5) step();
    i8k = 1'b1;
    repeat (5) step();
    i8k = 1'b0;
    step();
    step();
    step();
    chk("f2_E1_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      if (n == 900) i8k = 1'b1;
      if (n == 997) i8k = 1'b0;
      if (n == 2000) i8k = 1'b1;
      if (n == 2622) i8k = 1'b0;
      step();
      n++;
    end
    chk("f2_len", 32'(n), 32'd2624);
    chk("f2_end_ser", {30'b0, busy, ser}, 32'd0);
    chk("f2_ovr", 32'(novr), 32'd1);
    chk("f2_bits", 32'(nbits - b_bits), 32'd656);
    chk("f2_reads", 32'(nrd - b_rd), 32'd80);
    chk("f2_busy_cyc", 32'(busy_cyc - b_busy), 32'd2624);
    verify_frame("f2", b_bits);

    // Frame 3 starts in the cycle right after the previous frame ended.
    b_bits = nbits; b_rd = nrd; b_busy = busy_cyc;
    step();
    chk("f3_E1_out", {19'b0, rd_addr, rd_en, ser, stb, fsync, busy, ovr}, 32'h3E);
    run_to_end(-1, -1, n, fs_n, rd2_n);
    chk("f3_len", 32'(n), 32'd2624);
    chk("f3_bits", 32'(nbits - b_bits), 32'd656);
    chk("f3_reads", 32'(nrd - b_rd), 32'd80);
    chk("f3_ovr", 32'(novr), 32'd1);
    verify_frame("f3", b_bits);

    // Reset during channel 20's byte.
    start_edge("f4");
    repeat (710) step();
    chk("f4_mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk("f4_reset_outs", {19'b0, rd_addr, rd_en, ser, stb, fsync, busy, ovr}, 32'd0);
    i8k = 1'b1;
    repeat (4) step();
    rst_n = 1'b1;
    b_busy = busy_cyc;
    repeat (10) step();
    chk("f4_post_reset_idle", 32'(busy_cyc - b_busy), 32'd0);
    b_bits = nbits; b_rd = nrd;
    start_edge("f5");
    run_to_end(-1, -1, n, fs_n, rd2_n);
    chk("f5_len", 32'(n), 32'd2624);
    chk("f5_bits", 32'(nbits - b_bits), 32'd656);
    chk("f5_reads", 32'(nrd - b_rd), 32'd80);
    verify_frame("f5", b_bits);
    for (int k = 0; k < 80; k++) chk($sformatf("f5_addr%0d", k), 32'(rd_log[b_rd + k]), 32'(exp_addr(k)));
    chk("glitches", 32'(glitch), 32'd0);
    chk("idle_reads_total", 32'(rd_idle), 32'd0);

    // Single-channel instance, BIT_DIV=3.
    i8k1 = 1'b1;
    repeat (8) step();
    i8k1 = 1'b0;
    step();
    step();
    chk("c1_E_idle", 32'(busy1), 32'd0);
    step();
    chk("c1_E1_out", {19'b0, rd_addr1, rd_en1, ser1, stb1, fsync1, busy1, ovr1}, 32'h3E);
    n = 0;
    while (busy1 === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk("c1_len", 32'(n), 32'd72);
    chk("c1_busy_cyc", 32'(busy_cyc1), 32'd72);
    chk("c1_bits", 32'(nbits1), 32'd24);
    chk("c1_reads", 32'(nrd1), 32'd1);
    chk("c1_addr", 32'(rd_log1[0]), 32'd0);
    begin
      logic [23:0] w1;
      w1 = '0;
      for (int i = 0; i < 24; i++) w1 = {w1[22:0], bits1[i]};
      chk("c1_frame", 32'(w1), 32'hFAF301);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
